// File: rtl/lehmer_pkg.sv
// -----------------------------------------------------------------------------
// lehmer_pkg
// Shared declarations for the Lehmer PRNG sequencer:
//   - lehmer_state_e : sequencer FSM state encoding (3 bits)
//   - DEF_MULT_A     : default multiplier constant
//   - DEF_MODULUS    : default prime modulus
//   - SEED_ONE       : value substituted whenever a zero state would appear
//   - fix_zero()     : applies the zero-to-one substitution
// -----------------------------------------------------------------------------
package lehmer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DLOAD = 3'd2,
        ST_DWAIT = 3'd3,
        ST_OUT   = 3'd4
    } lehmer_state_e;

    localparam logic [15:0] DEF_MULT_A  = 16'd75;
    localparam logic [15:0] DEF_MODULUS = 16'd65521;
    localparam logic [15:0] SEED_ONE    = 16'd1;

    // A multiplicative generator stuck at zero never leaves zero, so zero is
    // never allowed into the state register.
    function automatic logic [15:0] fix_zero(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'd0) begin
            r = SEED_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/lehmer_seq_mul16.sv
// -----------------------------------------------------------------------------
// seq_mul16
// 16x16 shift-add multiplier, one multiplier bit per cycle, LSB first.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   clears the accumulator, captures mcand, bit counter = 0
//   mcand    in   16-bit multiplicand (captured on start)
//   mult     in   16-bit multiplier (must be held stable while running)
//   done     out  high during the cycle in which bit 15 is being added
//   product  out  32-bit product; valid in the cycle done is high
// The product is presented combinationally alongside done so the caller can
// register it on the same edge that retires the last bit.
// -----------------------------------------------------------------------------
module seq_mul16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mult,
    output logic        done,
    output logic [31:0] product
);

    logic        active_r;
    logic [3:0]  bit_r;
    logic [15:0] mcand_r;
    logic [31:0] acc_r;
    logic [31:0] addend_s;
    logic [31:0] acc_nxt_s;

    // Partial product for the current bit and the running sum it produces.
    always_comb begin
        addend_s = 32'd0;
        if (mult[bit_r]) begin
            addend_s = {16'd0, mcand_r} << bit_r;
        end else begin
            addend_s = 32'd0;
        end
        acc_nxt_s = acc_r + addend_s;
    end

    assign done    = active_r && (bit_r == 4'd15);
    assign product = acc_nxt_s;

    // Accumulator, multiplicand and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= 1'b0;
            bit_r    <= 4'd0;
            mcand_r  <= 16'd0;
            acc_r    <= 32'd0;
        end else if (start) begin
            active_r <= 1'b1;
            bit_r    <= 4'd0;
            mcand_r  <= mcand;
            acc_r    <= 32'd0;
        end else if (active_r) begin
            acc_r    <= acc_nxt_s;
            bit_r    <= bit_r + 4'd1;
            active_r <= (bit_r != 4'd15);
        end else begin
            acc_r    <= acc_r;
        end
    end

endmodule

// File: rtl/lehmer_seq.sv
// -----------------------------------------------------------------------------
// lehmer_seq
// Lehmer (multiplicative congruential) PRNG sequencer:
//   next_state = (MULT_A * state) mod MODULUS
// The product comes from seq_mul16; the reduction is done by an external
// 32-bit divider whose remainder becomes the new state and output sample.
//
// Parameters: MULT_A (16b), MODULUS (16b, nonzero), TIMEOUT (divider watchdog)
// Ports:
//   clk, rst           clock / synchronous active-high reset
//   seed_load/seed_val load a seed in IDLE (zero seed becomes 1)
//   gen_req            request next sample (level, sampled in IDLE)
//   rnd_out/rnd_valid  last sample (zero-extended) / 1-cycle update pulse
//   busy               high whenever the FSM is not in IDLE
//   div_en/div_y/div_x divider load strobe, dividend, divisor
//   div_r/div_done     divider remainder and completion pulse
//   err                sticky divider-timeout flag
//
// Optional feature: define LEHMER_SEQ_WATCHDOG_EN to enable a DWAIT
// watchdog. After TIMEOUT cycles without div_done, err is set, the state is
// kept and the previous sample is reissued. Without it, err is tied 0 and
// DWAIT waits indefinitely.
// -----------------------------------------------------------------------------
module lehmer_seq
    import lehmer_pkg::*;
#(
    parameter logic [15:0] MULT_A  = DEF_MULT_A,
    parameter logic [15:0] MODULUS = DEF_MODULUS,
    parameter int          TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [15:0] seed_val,
    input  logic        gen_req,
    output logic [31:0] rnd_out,
    output logic        rnd_valid,
    output logic        busy,
    output logic        div_en,
    output logic [31:0] div_y,
    output logic [31:0] div_x,
    input  logic [31:0] div_r,
    input  logic        div_done,
    output logic        err
);

    lehmer_state_e state_r;
    lehmer_state_e nxt_s;

    logic [15:0] prng_r;
    logic [31:0] rnd_out_r;
    logic        rnd_valid_r;
    logic        busy_r;
    logic        div_en_r;
    logic [31:0] div_y_r;
    logic [31:0] div_x_r;

    logic        mul_start_s;
    logic        mul_done_s;
    logic [31:0] mul_product_s;
    logic        div_acc_s;
    logic [15:0] div_rem_s;
    logic        wd_expire_s;

    // Only a completion seen while waiting counts; early or stray pulses drop.
    assign div_acc_s = (state_r == ST_DWAIT) && div_done;
    assign div_rem_s = fix_zero(div_r[15:0]);

    seq_mul16 u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .mcand   (prng_r),
        .mult    (MULT_A),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

`ifdef LEHMER_SEQ_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wd_cnt_r;
    logic        err_r;
    logic        unused_s;

    // A completion in the final watchdog cycle still wins over the timeout.
    assign wd_expire_s = (state_r == ST_DWAIT) && !div_done && (wd_cnt_r == WD_LAST);

    // Watchdog cycle counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= 16'd0;
            err_r    <= 1'b0;
        end else begin
            if (state_r == ST_DWAIT) begin
                wd_cnt_r <= wd_cnt_r + 16'd1;
            end else begin
                wd_cnt_r <= 16'd0;
            end
            if (wd_expire_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err      = err_r;
    assign unused_s = ^div_r[31:16];
`else
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    logic unused_s;

    assign wd_expire_s = 1'b0;
    assign err         = 1'b0;
    assign unused_s    = ^{div_r[31:16], TIMEOUT_W};
`endif

    // Next-state logic and multiplier launch.
    always_comb begin
        nxt_s       = state_r;
        mul_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (seed_load) begin
                    nxt_s = ST_IDLE;
                end else if (gen_req) begin
                    nxt_s       = ST_MUL;
                    mul_start_s = 1'b1;
                end else begin
                    nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    nxt_s = ST_DLOAD;
                end else begin
                    nxt_s = ST_MUL;
                end
            end
            ST_DLOAD: begin
                nxt_s = ST_DWAIT;
            end
            ST_DWAIT: begin
                if (div_done) begin
                    nxt_s = ST_OUT;
                end else if (wd_expire_s) begin
                    nxt_s = ST_OUT;
                end else begin
                    nxt_s = ST_DWAIT;
                end
            end
            ST_OUT: begin
                nxt_s = ST_IDLE;
            end
            default: begin
                nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, PRNG state and registered outputs. Strobes are computed from
    // the next state so they are high exactly during DLOAD / OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prng_r      <= SEED_ONE;
            rnd_out_r   <= 32'd0;
            rnd_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            div_en_r    <= 1'b0;
            div_y_r     <= 32'd0;
            div_x_r     <= 32'd0;
        end else begin
            state_r     <= nxt_s;
            busy_r      <= (nxt_s != ST_IDLE);
            div_en_r    <= (nxt_s == ST_DLOAD);
            rnd_valid_r <= (nxt_s == ST_OUT);

            if ((state_r == ST_IDLE) && seed_load) begin
                prng_r <= fix_zero(seed_val);
            end else if (div_acc_s) begin
                prng_r <= div_rem_s;
            end

            // Dividend/divisor stay put through DWAIT until the next product.
            if ((state_r == ST_MUL) && mul_done_s) begin
                div_y_r <= mul_product_s;
                div_x_r <= {16'd0, MODULUS};
            end

            // On a watchdog expiry prng_r is untouched, so the old sample repeats.
            if (div_acc_s) begin
                rnd_out_r <= {16'd0, div_rem_s};
            end else if (nxt_s == ST_OUT) begin
                rnd_out_r <= {16'd0, prng_r};
            end
        end
    end

    assign rnd_out   = rnd_out_r;
    assign rnd_valid = rnd_valid_r;
    assign busy      = busy_r;
    assign div_en    = div_en_r;
    assign div_y     = div_y_r;
    assign div_x     = div_x_r;

endmodule
